cam_capture: RTL

Camera pixel-capture stage that sits downstream of the SCCB-configured OV7670-class sensor and upstream of the VGA frame buffer. Oversamples the sensor's PCLK/VSYNC/HREF/D bus in the system clock domain, assembles two-byte RGB565 pixels, and issues single-cycle write strobes with linear frame-buffer addresses. Tracks frame boundaries, counts frames and flags malformed lines.

---
 rtl/cam_capture.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// Camera pixel capture: oversamples the sensor bus, assembles RGB565 pixels, writes them linearly into the frame buffer.
// Optional 2:1 decimation in both axes when CAM_CAPTURE_DECIM_EN is defined.
module cam_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err
);

  // Counters get headroom above the active size so over-long lines saturate instead of wrapping.
  localparam int XW = $clog2(H_ACTIVE + 2) + 1;
  localparam int YW = $clog2(V_ACTIVE + 2) + 1;

  localparam logic [XW-1:0]     H_LIM  = XW'(H_ACTIVE);
  localparam logic [XW-1:0]     X_MAX  = '1;
  localparam logic [YW-1:0]     V_LIM  = YW'(V_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX  = '1;
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_HALF = ADDR_W'(H_ACTIVE / 2);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [2:0] pclk_sr, vs_sr, href_sr;
  logic [7:0] d_s1, d_s2, d_hist;

  logic pclk_pos_q, href_rise_q, href_fall_q, vs_rise_q, vs_fall_q;

  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              phase;
  logic [7:0]        hi_byte;

  logic              phase_eff;
  logic              in_range;
  logic              wr_ok;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] line_step;

  // Bit 0 and 1 are the synchronizer pair, bit 2 the history flop; data shares the same depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      href_sr <= '0;
      d_s1    <= '0;
      d_s2    <= '0;
      d_hist  <= '0;
    end else begin
      pclk_sr <= {pclk_sr[1:0], cam_pclk};
      vs_sr   <= {vs_sr[1:0], cam_vsync};
      href_sr <= {href_sr[1:0], cam_href};
      d_s1    <= cam_d;
      d_s2    <= d_s1;
      d_hist  <= d_s2;
    end
  end

  // Edge flags are registered, which lines them up with href_sr[2] and d_hist.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pclk_pos_q  <= 1'b0;
      href_rise_q <= 1'b0;
      href_fall_q <= 1'b0;
      vs_rise_q   <= 1'b0;
      vs_fall_q   <= 1'b0;
    end else begin
      pclk_pos_q  <= (pclk_sr[2:1] == 2'b01);
      href_rise_q <= (href_sr[2:1] == 2'b01);
      href_fall_q <= (href_sr[2:1] == 2'b10);
      vs_rise_q   <= (vs_sr[2:1] == 2'b01);
      vs_fall_q   <= (vs_sr[2:1] == 2'b10);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!capture_en)    state_nxt = IDLE;
        else if (vs_fall_q) state_nxt = ACTIVE;
      end
      ACTIVE:  if (vs_rise_q) state_nxt = capture_en ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    phase_eff = href_rise_q ? 1'b0 : phase;
    in_range  = (x_cnt < H_LIM) && (y_cnt < V_LIM);
`ifdef CAM_CAPTURE_DECIM_EN
    wr_ok     = in_range && !x_cnt[0] && !y_cnt[0];
    pix_addr  = line_base + ADDR_W'(x_cnt >> 1);
    line_step = y_cnt[0] ? '0 : H_HALF;
`else
    wr_ok     = in_range;
    pix_addr  = line_base + ADDR_W'(x_cnt);
    line_step = H_STEP;
`endif
  end

  // A vsync rise ends the frame outright, so a partial line in flight is neither counted nor checked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      line_base  <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (state != WAIT_VS && state_nxt == WAIT_VS) line_err <= 1'b0;
      if (state != ACTIVE) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        line_base <= '0;
        phase     <= 1'b0;
      end else if (vs_rise_q) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
        x_cnt      <= '0;
        y_cnt      <= '0;
        line_base  <= '0;
        phase      <= 1'b0;
      end else begin
        if (href_rise_q) phase <= 1'b0;
        if (pclk_pos_q && href_sr[2]) begin
          if (!phase_eff) begin
            hi_byte <= d_hist;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (wr_ok) begin
              wr_en   <= 1'b1;
              wr_addr <= pix_addr;
              wr_data <= {hi_byte, d_hist};
            end
            if (x_cnt != X_MAX) x_cnt <= x_cnt + 1'b1;
          end
        end
        if (href_fall_q) begin
          if (x_cnt != H_LIM) line_err <= 1'b1;
          if (y_cnt < V_LIM)  line_base <= line_base + line_step;
          if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
          x_cnt <= '0;
          phase <= 1'b0;
        end
      end
    end
  end

endmodule
